// File: rtl/grid_video_scanout_pkg.sv
// Shared types and constants for the grid video scanout path.
package grid_video_scanout_pkg;

  localparam int GRID_WIDTH  = 25;
  localparam int GRID_HEIGHT = 25;

  typedef logic [7:0] value_t;
  localparam int VALUE_BITS = $bits(value_t);

  typedef logic [$clog2(GRID_WIDTH)-1:0]  col_t;
  typedef logic [$clog2(GRID_HEIGHT)-1:0] row_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } scan_state_e;

  // drop_count saturates here instead of wrapping back to zero.
  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/grid_video_scanout_scan_counter.sv
// Row-major raster counter: x runs 0..WIDTH-1, then y advances; wraps to (0,0) after the last cell.
module grid_scan_counter
  import grid_video_scanout_pkg::*;
#(
  parameter int  WIDTH  = GRID_WIDTH,
  parameter int  HEIGHT = GRID_HEIGHT,
  localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          eol,
  output logic          eof
);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          eol_s;
  logic          eof_s;

  // Decode end-of-row / end-of-frame from the current position.
  always_comb begin
    eol_s = (x_r == XW'(WIDTH - 1));
    eof_s = eol_s && (y_r == YW'(HEIGHT - 1));
  end

  // Position register: clear has priority, otherwise advance one cell per enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (clear) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (enable) begin
      if (eol_s) begin
        x_r <= {XW{1'b0}};
        if (eof_s) begin
          y_r <= {YW{1'b0}};
        end else begin
          y_r <= y_r + YW'(1);
        end
      end else begin
        x_r <= x_r + XW'(1);
        y_r <= y_r;
      end
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

  assign x   = x_r;
  assign y   = y_r;
  assign eol = eol_s;
  assign eof = eof_s;

endmodule

// File: rtl/grid_video_scanout.sv
// Snapshots the whole cell grid on a frame request and streams it row-major over a
// valid/ready link with coordinates and sof/eol/eof markers.
module grid_video_scanout
  import grid_video_scanout_pkg::*;
#(
  parameter int  WIDTH   = GRID_WIDTH,
  parameter int  HEIGHT  = GRID_HEIGHT,
  parameter int  VALUE_W = VALUE_BITS,
  localparam int XW      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int FLAT_W  = WIDTH * HEIGHT * VALUE_W,
  localparam int BW      = (FLAT_W > 1) ? $clog2(FLAT_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLAT_W-1:0]  video_flat,
  input  logic               frame_req,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [VALUE_W-1:0] pix_data,
  output logic [XW-1:0]      pix_x,
  output logic [YW-1:0]      pix_y,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               busy,
  output logic [7:0]         drop_count
);

  scan_state_e       state_r;
  logic [FLAT_W-1:0] shadow_r;
  logic              valid_r;
  logic              busy_r;
  logic [7:0]        drop_count_r;

  logic              handshake_s;
  logic              last_accept_s;
  logic              capture_s;
  logic [XW-1:0]     x_s;
  logic [YW-1:0]     y_s;
  logic              eol_s;
  logic              eof_s;
  logic [BW-1:0]     base_s;
  logic [VALUE_W-1:0] pix_data_s;
  logic              sof_s;

  // Handshake and capture qualification; a request on the final accept chains the next frame.
  always_comb begin
    handshake_s   = valid_r & pix_ready;
    last_accept_s = handshake_s & eof_s;
    capture_s     = frame_req & ((state_r == IDLE) | last_accept_s);
  end

  grid_scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (capture_s),
    .enable (handshake_s),
    .x      (x_s),
    .y      (y_s),
    .eol    (eol_s),
    .eof    (eof_s)
  );

  // Scan FSM: capture, stream, chain back-to-back frames and count ignored requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      shadow_r     <= {FLAT_W{1'b0}};
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_req) begin
            shadow_r <= video_flat;
            state_r  <= STREAM;
            valid_r  <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        STREAM: begin
          if (last_accept_s) begin
            if (frame_req) begin
              shadow_r <= video_flat;
            end else begin
              state_r  <= IDLE;
              valid_r  <= 1'b0;
              busy_r   <= 1'b0;
            end
          end else if (frame_req) begin
            if (drop_count_r != DROP_MAX) begin
              drop_count_r <= drop_count_r + 8'd1;
            end else begin
              drop_count_r <= drop_count_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read the current cell out of the shadow buffer and decode markers from the position.
  always_comb begin
    base_s     = BW'((32'(y_s) * WIDTH + 32'(x_s)) * VALUE_W);
    pix_data_s = shadow_r[base_s +: VALUE_W];
    sof_s      = valid_r & (x_s == {XW{1'b0}}) & (y_s == {YW{1'b0}});
  end

  assign pix_valid  = valid_r;
  assign pix_data   = pix_data_s;
  assign pix_x      = x_s;
  assign pix_y      = y_s;
  assign pix_sof    = sof_s;
  assign pix_eol    = valid_r & eol_s;
  assign pix_eof    = valid_r & eof_s;
  assign busy       = busy_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_grid_video_scanout.sv
// Self-checking bench for grid_video_scanout against a frame-index reference model.
module tb_grid_video_scanout;

  localparam int W  = 25;
  localparam int H  = 25;
  localparam int VW = 8;
  localparam int N  = W * H;
  localparam int FW = N * VW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] video_flat = '0;
  logic          frame_req = 1'b0;
  logic          pix_ready = 1'b0;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic [4:0]    pix_x;
  logic [4:0]    pix_y;
  logic          pix_sof, pix_eol, pix_eof, busy;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] obs_data[$];
  int         obs_x[$];
  int         obs_y[$];
  bit         obs_sof[$];
  bit         obs_eol[$];
  bit         obs_eof[$];
  int         hold_viol;
  int         first_bad;
  logic [FW-1:0] snap_next;

  grid_video_scanout dut (
    .clk        (clk),
    .rst        (rst),
    .video_flat (video_flat),
    .frame_req  (frame_req),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] pattern_video();
    logic [FW-1:0] v;
    for (int k = 0; k < N; k++) v[k*VW +: VW] = 8'(k);
    return v;
  endfunction

  function automatic logic [FW-1:0] rand_video();
    logic [FW-1:0] v;
    for (int k = 0; k < N; k++) v[k*VW +: VW] = 8'($urandom);
    return v;
  endfunction

  // Reference: pixel k of a frame is cell (k%W, k/W) of the captured snapshot.
  function automatic int count_bad(input logic [FW-1:0] snap);
    int bad = 0;
    logic [7:0] ev;
    first_bad = -1;
    for (int k = 0; k < obs_data.size() && k < N; k++) begin
      ev = snap[k*VW +: VW];
      if (obs_data[k] !== ev || obs_x[k] != k % W || obs_y[k] != k / W ||
          obs_sof[k] != (k == 0) || obs_eol[k] != (k % W == W - 1) || obs_eof[k] != (k == N - 1)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    return bad;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; frame_req = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [FW-1:0] v);
    video_flat = v;
    frame_req  = 1'b1;
    @(negedge clk);
    frame_req  = 1'b0;
  endtask

  // Sink one frame into the obs_* queues; records hold-rule violations. Starts and ends at a negedge.
  task automatic collect(input int ready_pct, input bit wiggle, input int n_req,
                         input bit req_at_eof, output bit timed_out);
    int cycles = 0;
    bit done = 0;
    bit stalled = 0;
    logic [7:0] h_data;
    logic [4:0] h_x, h_y;
    logic h_sof, h_eol, h_eof;
    logic [31:0] r;
    obs_data.delete(); obs_x.delete(); obs_y.delete();
    obs_sof.delete(); obs_eol.delete(); obs_eof.delete();
    hold_viol = 0;
    timed_out = 1'b0;
    while (!done) begin
      if (stalled) begin
        if (!pix_valid || pix_data !== h_data || pix_x !== h_x || pix_y !== h_y ||
            pix_sof !== h_sof || pix_eol !== h_eol || pix_eof !== h_eof)
          hold_viol++;
      end
      pix_ready = ($urandom_range(99) < ready_pct);
      frame_req = 1'b0;
      if (n_req > 0) begin
        frame_req = 1'b1;
        n_req--;
      end
      if (wiggle) begin
        r = $urandom | 32'h1;
        video_flat = video_flat ^ FW'({157{r}});
      end
      if (pix_valid && pix_ready) begin
        obs_data.push_back(pix_data);
        obs_x.push_back(int'(pix_x));
        obs_y.push_back(int'(pix_y));
        obs_sof.push_back(pix_sof);
        obs_eol.push_back(pix_eol);
        obs_eof.push_back(pix_eof);
        if (pix_eof) begin
          done = 1;
          if (req_at_eof) begin
            video_flat = rand_video();
            snap_next  = video_flat;
            frame_req  = 1'b1;
          end
        end
      end
      stalled = pix_valid && !pix_ready;
      h_data = pix_data; h_x = pix_x; h_y = pix_y;
      h_sof = pix_sof; h_eol = pix_eol; h_eof = pix_eof;
      @(negedge clk);
      cycles++;
      if (!done && cycles > 20 * N) begin
        timed_out = 1'b1;
        done = 1;
      end
    end
    frame_req = 1'b0;
    pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", pix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (pix_x !== 5'd0 || pix_y !== 5'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", pix_x, pix_y); end
    checks++; if (pix_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d want 0", pix_data); end
    checks++; if ({pix_sof, pix_eol, pix_eof} !== 3'b000) begin errors++; $display("FAIL reset_markers got %b want 000", {pix_sof, pix_eol, pix_eof}); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops got %0d want 0", drop_count); end
  endtask

  task automatic test_raster();
    bit to;
    int bad;
    logic [FW-1:0] snap;
    snap = pattern_video();
    start_frame(snap);
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL raster_latency valid got %0b want 1", pix_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL raster_busy got %0b want 1", busy); end
    collect(100, 1'b0, 0, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL raster_timeout got %0b want 0", to); end
    checks++; if (obs_data.size() != N) begin errors++; $display("FAIL raster_count got %0d want %0d", obs_data.size(), N); end
    bad = count_bad(snap);
    checks++; if (bad != 0) begin errors++; $display("FAIL raster_content bad %0d first at %0d want 0", bad, first_bad); end
    checks++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL raster_idle valid/busy got %0b/%0b want 0/0", pix_valid, busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    logic [FW-1:0] snap;
    snap = rand_video();
    start_frame(snap);
    collect(50, 1'b0, 0, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %0b want 0", to); end
    checks++; if (obs_data.size() != N) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_data.size(), N); end
    bad = count_bad(snap);
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_content bad %0d first at %0d want 0", bad, first_bad); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold violations %0d want 0", hold_viol); end
  endtask

  task automatic test_snapshot();
    bit to;
    int bad;
    logic [FW-1:0] snap;
    snap = rand_video();
    start_frame(snap);
    collect(100, 1'b1, 0, 1'b0, to);
    checks++; if (obs_data.size() != N) begin errors++; $display("FAIL snap_count got %0d want %0d", obs_data.size(), N); end
    bad = count_bad(snap);
    checks++; if (bad != 0) begin errors++; $display("FAIL snap_content bad %0d first at %0d want 0", bad, first_bad); end
  endtask

  task automatic test_drop_saturation();
    bit to;
    int bad;
    logic [FW-1:0] snap;
    snap = rand_video();
    start_frame(snap);
    collect(100, 1'b0, 300, 1'b0, to);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_count); end
    checks++; if (obs_data.size() != N) begin errors++; $display("FAIL drop_count_px got %0d want %0d", obs_data.size(), N); end
    bad = count_bad(snap);
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_content bad %0d first at %0d want 0", bad, first_bad); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad;
    logic [FW-1:0] snap;
    do_reset();
    snap = rand_video();
    start_frame(snap);
    collect(100, 1'b0, 0, 1'b1, to);
    bad = count_bad(snap);
    checks++; if (bad != 0 || obs_data.size() != N) begin errors++; $display("FAIL b2b_first bad %0d size %0d want 0 %0d", bad, obs_data.size(), N); end
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b want 1", pix_valid); end
    checks++; if (pix_x !== 5'd0 || pix_y !== 5'd0 || pix_sof !== 1'b1) begin errors++; $display("FAIL b2b_restart x %0d y %0d sof %0b want 0 0 1", pix_x, pix_y, pix_sof); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL b2b_drops got %0d want 0", drop_count); end
    collect(100, 1'b0, 0, 1'b0, to);
    bad = count_bad(snap_next);
    checks++; if (bad != 0 || obs_data.size() != N) begin errors++; $display("FAIL b2b_second bad %0d size %0d want 0 %0d", bad, obs_data.size(), N); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL b2b_hold violations %0d want 0", hold_viol); end
  endtask

  task automatic test_reset_midstream();
    bit to;
    int bad;
    logic [FW-1:0] snap;
    snap = rand_video();
    start_frame(snap);
    for (int c = 0; c < 100; c++) begin
      frame_req = (c < 3);
      pix_ready = 1'b1;
      @(negedge clk);
    end
    frame_req = 1'b0;
    pix_ready = 1'b0;
    checks++; if (int'(pix_x) != 100 % W || int'(pix_y) != 100 / W || pix_data !== snap[100*VW +: VW]) begin
      errors++; $display("FAIL mid_position x %0d y %0d data %0d want %0d %0d %0d", pix_x, pix_y, pix_data, 100 % W, 100 / W, snap[100*VW +: VW]);
    end
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL mid_drops got %0d want 3", drop_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async valid/busy got %0b/%0b want 0/0", pix_valid, busy); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drops_clear got %0d want 0", drop_count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    snap = rand_video();
    start_frame(snap);
    checks++; if (pix_valid !== 1'b1 || pix_sof !== 1'b1) begin errors++; $display("FAIL mid_restart valid/sof got %0b/%0b want 1/1", pix_valid, pix_sof); end
    collect(70, 1'b0, 0, 1'b0, to);
    bad = count_bad(snap);
    checks++; if (bad != 0 || obs_data.size() != N) begin errors++; $display("FAIL mid_refill bad %0d size %0d want 0 %0d", bad, obs_data.size(), N); end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_backpressure();
    test_snapshot();
    test_drop_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
